// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-ported register file: ID width helper,
// register-ID type and the index of the hardwired-zero register.
package reg_file_pkg;

  localparam int MAX_AW  = 8;
  localparam int ZERO_ID = 0;

  typedef logic [MAX_AW-1:0] reg_id_t;

  function automatic int id_width(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, cleared by write-back and set by
// issue, with issue taking priority when both target the same register.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NWR      = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] wr_id_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_id_i,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (we_i[w]) busy_d[wr_id_i[w*AW +: AW]] = 1'b0;
    end
    // A fresh reservation outlives a write-back retiring an older one.
    if (iss_en_i) busy_d[iss_id_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_ID] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with combinational reads, optional write-to-read
// forwarding, optional hardwired-zero R0 and an integrated busy scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = id_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rd_id,
  output logic [NRD*DWIDTH-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wr_id,
  input  logic [NWR*DWIDTH-1:0] wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_id,
  output logic [NREGS-1:0]      busy_vec
);

  logic [DWIDTH-1:0] reg_val [NREGS];

  reg_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .wr_id_i  (wr_id),
    .iss_en_i (iss_en),
    .iss_id_i (iss_id),
    .busy_o   (busy_vec)
  );

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if ((ZERO_REG != 0) && (r == ZERO_ID)) begin : g_zero
      assign reg_val[r] = '0;
    end else begin : g_flop
      logic              wr_hit;
      logic [DWIDTH-1:0] wr_val;
      logic [DWIDTH-1:0] val_q;

      // Ascending scan so the highest-indexed write port wins a conflict.
      always_comb begin
        wr_hit = 1'b0;
        wr_val = '0;
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && (wr_id[w*AW +: AW] == AW'(r))) begin
            wr_hit = 1'b1;
            wr_val = wr_data[w*DWIDTH +: DWIDTH];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      val_q <= '0;
        else if (wr_hit) val_q <= wr_val;
      end

      assign reg_val[r] = val_q;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]     id;
    logic [DWIDTH-1:0] data;
    logic              hit;
    logic              busy;

    // Forwarding is suppressed in reset so reads stay zero while rst_n is low.
    always_comb begin
      id   = rd_id[p*AW +: AW];
      data = reg_val[id];
      hit  = 1'b0;
      if ((BYPASS != 0) && rst_n) begin
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && (wr_id[w*AW +: AW] == id)) begin
            hit  = 1'b1;
            data = wr_data[w*DWIDTH +: DWIDTH];
          end
        end
      end
      busy = busy_vec[id] & ~hit;
      if ((ZERO_REG != 0) && (id == AW'(ZERO_ID))) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[p*DWIDTH +: DWIDTH] = data;
    assign rd_busy[p]                  = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a default forwarding build and a
// non-forwarding 16x64, 3-read build with a randomised reference-model run.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Build A: defaults (32x32, 2R/2W, BYPASS=1, ZERO_REG=1)
  logic [9:0]  a_rd_id;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_we;
  logic [9:0]  a_wr_id;
  logic [63:0] a_wr_data;
  logic        a_iss_en;
  logic [4:0]  a_iss_id;
  logic [31:0] a_busy_vec;

  // Build B: 16x64, 3R/2W, BYPASS=0, ZERO_REG=0
  logic [11:0]  b_rd_id;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [1:0]   b_we;
  logic [7:0]   b_wr_id;
  logic [127:0] b_wr_data;
  logic         b_iss_en;
  logic [3:0]   b_iss_id;
  logic [15:0]  b_busy_vec;

  reg_file_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_id(a_rd_id), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .we(a_we), .wr_id(a_wr_id), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_id(a_iss_id), .busy_vec(a_busy_vec)
  );

  reg_file_mp #(
    .DWIDTH(64), .NREGS(16), .NRD(3), .NWR(2), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_id(b_rd_id), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .we(b_we), .wr_id(b_wr_id), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_id(b_iss_id), .busy_vec(b_busy_vec)
  );

  task automatic a_idle();
    a_we = '0; a_wr_id = '0; a_wr_data = '0; a_iss_en = 1'b0; a_iss_id = '0;
  endtask

  task automatic b_idle();
    b_we = '0; b_wr_id = '0; b_wr_data = '0; b_iss_en = 1'b0; b_iss_id = '0;
  endtask

  task automatic test_reset();
    a_idle(); b_idle();
    a_rd_id = {5'd0, 5'd5};
    b_rd_id = '0;
    #1;
    checks++;
    if (a_busy_vec !== 32'h0 || a_rd_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_initial busy_vec=%h rd_data=%h required 0/0", a_busy_vec, a_rd_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    a_we = 2'b01; a_wr_id = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEAD};
    a_iss_en = 1'b1; a_iss_id = 5'd6;
    @(posedge clk); #1;
    checks++;
    if (a_rd_data[31:0] !== 32'hDEAD || a_busy_vec !== 32'h40) begin
      errors++;
      $display("FAIL reset_prewrite R5=%h busy_vec=%h required DEAD/00000040", a_rd_data[31:0], a_busy_vec);
    end
    a_idle();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h0 || a_busy_vec !== 32'h0 || a_rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_async R5=%h busy_vec=%h rd_busy=%b required 0/0/00",
               a_rd_data[31:0], a_busy_vec, a_rd_busy);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_rd_data[31:0] !== 32'h0 || a_busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL reset_release R5=%h busy_vec=%h required 0/0", a_rd_data[31:0], a_busy_vec);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    a_we = 2'b11; a_wr_id = {5'd7, 5'd7}; a_wr_data = {32'h22, 32'h11};
    a_rd_id = {5'd7, 5'd0};
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'h22) begin
      errors++;
      $display("FAIL dual_write_bypass R7=%h required 00000022", a_rd_data[63:32]);
    end
    @(negedge clk); a_idle();
    #1;
    checks++;
    if (a_rd_data[63:32] !== 32'h22 || a_busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL dual_write_stored R7=%h busy_vec=%h required 00000022/0", a_rd_data[63:32], a_busy_vec);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a_we = 2'b01; a_wr_id = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'hA5A5};
    a_rd_id = {5'd0, 5'd3};
    b_we = 2'b01; b_wr_id = {4'd0, 4'd3}; b_wr_data = {64'h0, 64'hA5A5};
    b_rd_id = {4'd3, 4'd0, 4'd0};
    #1;
    checks++;
    if (a_rd_data[31:0] !== 32'hA5A5) begin
      errors++;
      $display("FAIL bypass_on R3=%h required 0000A5A5", a_rd_data[31:0]);
    end
    checks++;
    if (b_rd_data[191:128] !== 64'h0) begin
      errors++;
      $display("FAIL bypass_off_same R3=%h required 0", b_rd_data[191:128]);
    end
    @(posedge clk); #1;
    checks++;
    if (b_rd_data[191:128] !== 64'hA5A5) begin
      errors++;
      $display("FAIL bypass_off_next R3=%h required A5A5", b_rd_data[191:128]);
    end
    @(negedge clk); a_idle(); b_idle();
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    a_iss_en = 1'b1; a_iss_id = 5'd9; a_rd_id = {5'd0, 5'd9};
    #1;
    checks++;
    if (a_rd_busy[0] !== 1'b0 || a_busy_vec[9] !== 1'b0) begin
      errors++;
      $display("FAIL sb_issue_same rd_busy=%b busy9=%b required 0/0", a_rd_busy[0], a_busy_vec[9]);
    end
    @(posedge clk); #1;
    checks++;
    if (a_busy_vec !== 32'h200 || a_rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue_next busy_vec=%h rd_busy=%b required 00000200/1", a_busy_vec, a_rd_busy[0]);
    end
    // second issue to an already-busy register (WAW)
    @(posedge clk); #1;
    checks++;
    if (a_busy_vec !== 32'h200) begin
      errors++;
      $display("FAIL sb_waw busy_vec=%h required 00000200", a_busy_vec);
    end
    @(negedge clk); a_idle();
    a_we = 2'b10; a_wr_id = {5'd9, 5'd0}; a_wr_data = {32'h99, 32'h0};
    #1;
    checks++;
    if (a_rd_busy[0] !== 1'b0 || a_rd_data[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL sb_wb_bypass rd_busy=%b R9=%h required 0/00000099", a_rd_busy[0], a_rd_data[31:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (a_busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL sb_wb_clear busy_vec=%h required 0", a_busy_vec);
    end
    @(negedge clk); a_idle();
    a_iss_en = 1'b1; a_iss_id = 5'd9;
    a_we = 2'b01; a_wr_id = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h1234};
    @(negedge clk); a_idle();
    #1;
    checks++;
    if (a_busy_vec !== 32'h200 || a_rd_busy[0] !== 1'b1 || a_rd_data[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL sb_set_wins busy_vec=%h rd_busy=%b R9=%h required 00000200/1/00001234",
               a_busy_vec, a_rd_busy[0], a_rd_data[31:0]);
    end
    a_we = 2'b01; a_wr_id = {5'd0, 5'd9}; a_wr_data = {32'h0, 32'h1234};
    @(negedge clk); a_idle();
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    a_we = 2'b01; a_wr_id = {5'd0, 5'd0}; a_wr_data = {32'h0, 32'hFFFF_FFFF};
    a_iss_en = 1'b1; a_iss_id = 5'd0; a_rd_id = {5'd0, 5'd0};
    #1;
    checks++;
    if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL zero_same rd_data=%h rd_busy=%b required 0/00", a_rd_data, a_rd_busy);
    end
    @(negedge clk); a_idle();
    #1;
    checks++;
    if (a_rd_data !== 64'h0 || a_busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL zero_next rd_data=%h busy_vec=%h required 0/0", a_rd_data, a_busy_vec);
    end
  endtask

  task automatic test_random();
    logic [63:0] m_reg [16];
    logic [15:0] m_busy;
    logic [3:0]  rid;
    logic [3:0]  wid;
    logic [64:0] exp_v;
    logic [64:0] got_v;
    for (int r = 0; r < 16; r++) m_reg[r] = 64'h0;
    m_reg[3] = 64'hA5A5;
    m_busy = 16'h0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      b_we      = 2'($urandom_range(0, 3));
      b_wr_id   = 8'($urandom);
      b_wr_data = {$urandom, $urandom, $urandom, $urandom};
      b_iss_en  = 1'($urandom_range(0, 1));
      b_iss_id  = 4'($urandom);
      b_rd_id   = 12'($urandom);
      #1;
      for (int p = 0; p < 3; p++) begin
        rid   = b_rd_id[p*4 +: 4];
        exp_v = {m_busy[rid], m_reg[rid]};
        got_v = {b_rd_busy[p], b_rd_data[p*64 +: 64]};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL rand_read cyc=%0d port=%0d id=%0d got=%h required=%h", cyc, p, rid, got_v, exp_v);
        end
      end
      checks++;
      if (b_busy_vec !== m_busy) begin
        errors++;
        $display("FAIL rand_busy_vec cyc=%0d got=%h required=%h", cyc, b_busy_vec, m_busy);
      end
      for (int w = 0; w < 2; w++) begin
        if (b_we[w]) begin
          wid = b_wr_id[w*4 +: 4];
          m_reg[wid]  = b_wr_data[w*64 +: 64];
          m_busy[wid] = 1'b0;
        end
      end
      if (b_iss_en) m_busy[b_iss_id] = 1'b1;
    end
    @(negedge clk); b_idle();
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
